// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with a one-cycle byte strobe.
// data_o carries the received byte only in the valid_o cycle, 0x00 otherwise.
// Optional even-parity (8E1) support is compiled in with the UART_PARITY_EN macro.
module uart_byte_rx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t          state_q, state_d;
   logic            rxd_meta_q, rxd_s_q;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            par_bad;
   logic            tick_half, tick_full;

`ifdef UART_PARITY_EN
   logic            par_err_q, par_err_d;
`endif

   assign tick_half = (timer_q == HALF_M1);
   assign tick_full = (timer_q == FULL_M1);

`ifdef UART_PARITY_EN
   assign par_bad = par_err_q;
`else
   assign par_bad = 1'b0;
`endif

   // Two-flop synchronizer for the asynchronous line; idles high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bit timer, bit index, shift register (and parity flag) registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
`ifdef UART_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
`ifdef UART_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
`ifdef UART_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (!rxd_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
`ifdef UART_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (tick_half) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = rxd_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick_full) begin
               timer_d = '0;
               shift_d = {rxd_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (tick_full) begin
               timer_d   = '0;
               par_err_d = ^{shift_q, rxd_s_q};
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick_full) begin
               timer_d = '0;
               state_d = rxd_s_q ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            timer_d = '0;
            if (rxd_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            timer_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: strobe byte or error at the stop-bit sample.
   always_comb begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      data_d  = '0;
      busy_o  = (state_q != S_IDLE);
      if (state_q == S_STOP && tick_full) begin
         if (rxd_s_q && !par_bad) begin
            valid_d = 1'b1;
            data_d  = shift_q;
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   // Registered outputs; data_o returns to 0x00 whenever no byte is strobed.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: table of frames, randomized frames and
// hand-written corner sequences, checked against a frame-level timing model.
// Honours UART_PARITY_EN when the design is built with it.
module tb_uart_byte_rx;

   localparam int unsigned CPB  = 16;
   localparam int unsigned MAXC = 65536;
   localparam int unsigned SYNC_LAT = 3;
`ifdef UART_PARITY_EN
   localparam int unsigned NBITS = 10;
`else
   localparam int unsigned NBITS = 9;
`endif

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic        par_ok;
      int unsigned gap;
      logic        exp_valid;
      logic [7:0]  exp_data;
   } vec_t;

   typedef struct {
      int unsigned cyc;
      logic        is_valid;
      logic [7:0]  data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       busy_o;

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;

   logic       hist_valid [MAXC];
   logic       hist_ferr  [MAXC];
   logic [7:0] hist_data  [MAXC];
   logic       hist_busy  [MAXC];

   ev_t  exp_q[$];
   vec_t vecs[10];

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .frame_err_o(frame_err_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record outputs mid-cycle, indexed by the number of the preceding rising edge.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         hist_valid[cyc] = valid_o;
         hist_ferr[cyc]  = frame_err_o;
         hist_data[cyc]  = data_o;
         hist_busy[cyc]  = busy_o;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic b, input int unsigned n);
      rxd = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame starting now and queues the expected strobe. The strobe
   // edge follows from sync latency + half-bit start check + NBITS whole bits.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                             input logic exp_valid, input logic [7:0] exp_data);
      int unsigned e;
      ev_t ev;
      e = cyc;
      if (e + 400 >= MAXC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", e, MAXC - 400);
         $fatal(1, "cycle budget exhausted");
      end
      ev.cyc      = e + SYNC_LAT + CPB / 2 + NBITS * CPB;
      ev.is_valid = exp_valid;
      ev.data     = exp_data;
      exp_q.push_back(ev);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_PARITY_EN
      hold((^d) ^ ~par_ok, CPB);
`endif
      hold(stop, CPB);
   endtask

   task automatic check_window(input string name, input int unsigned from, input int unsigned to);
      ev_t obs[$];
      int unsigned bad;
      int unsigned n;
      bad = 0;
      for (int unsigned c = from; c <= to; c++) begin
         if (hist_valid[c] === 1'b1 && hist_ferr[c] === 1'b1) bad++;
         if (hist_valid[c] !== 1'b1 && hist_data[c] !== 8'h00) bad++;
         if (hist_valid[c] === 1'b1 || hist_ferr[c] === 1'b1)
            obs.push_back('{c, hist_valid[c], hist_data[c]});
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_invariants: got %0d bad cycles expected 0", name, bad);
      end
      checks++;
      if (obs.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d pulses expected %0d", name, obs.size(), exp_q.size());
      end
      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int unsigned i = 0; i < n; i++) begin
         checks++;
         if (obs[i].cyc != exp_q[i].cyc || obs[i].is_valid !== exp_q[i].is_valid ||
             obs[i].data !== exp_q[i].data) begin
            failures++;
            $display("FAIL %s_ev%0d: got cyc=%0d valid=%0b data=%02h expected cyc=%0d valid=%0b data=%02h",
                     name, i, obs[i].cyc, obs[i].is_valid, obs[i].data,
                     exp_q[i].cyc, exp_q[i].is_valid, exp_q[i].data);
         end
      end
      exp_q.delete();
   endtask

   initial begin
      int unsigned win;
      int unsigned e;
      logic [7:0]  d;
      logic        st, pok;

      //            data   stop  par  gap  valid  data
      vecs[0] = '{8'h43, 1'b1, 1'b1,  0, 1'b1, 8'h43};
      vecs[1] = '{8'h44, 1'b1, 1'b1,  0, 1'b1, 8'h44};
      vecs[2] = '{8'h41, 1'b1, 1'b1,  0, 1'b1, 8'h41};
      vecs[3] = '{8'h43, 1'b1, 1'b1, 20, 1'b1, 8'h43};
      vecs[4] = '{8'h00, 1'b1, 1'b1,  5, 1'b1, 8'h00};
      vecs[5] = '{8'hFF, 1'b1, 1'b1,  0, 1'b1, 8'hFF};
      vecs[6] = '{8'h55, 1'b0, 1'b1,  8, 1'b0, 8'h00};
      vecs[7] = '{8'hAA, 1'b1, 1'b1,  3, 1'b1, 8'hAA};
      vecs[8] = '{8'h80, 1'b1, 1'b1,  0, 1'b1, 8'h80};
      vecs[9] = '{8'h01, 1'b1, 1'b1, 30, 1'b1, 8'h01};

      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", 32'(data_o), 32'h0);
      chk("reset_valid", 32'(valid_o), 32'h0);
      chk("reset_ferr", 32'(frame_err_o), 32'h0);
      chk("reset_busy", 32'(busy_o), 32'h0);
      rst = 1'b0;
      hold(1'b1, 10);

      // Table: includes four back-to-back frames 160 cycles apart.
      win = cyc;
      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_ok, vecs[i].exp_valid, vecs[i].exp_data);
         hold(1'b1, vecs[i].gap);
      end
      hold(1'b1, 200);
      check_window("table", win, cyc - 1);

      // Randomized frames; after a bad stop bit the line must return high first.
      win = cyc;
      for (int i = 0; i < 40; i++) begin
         d   = 8'($urandom);
         st  = ($urandom_range(0, 5) != 0);
`ifdef UART_PARITY_EN
         pok = ($urandom_range(0, 3) != 0);
`else
         pok = 1'b1;
`endif
         send_frame(d, st, pok, st & pok, (st & pok) ? d : 8'h00);
         hold(1'b1, st ? $urandom_range(0, 12) : $urandom_range(4, 12));
      end
      hold(1'b1, 200);
      check_window("random", win, cyc - 1);

      // False start: 4 low cycles; busy covers T0 .. T0+CPB/2.
      win = cyc;
      e = cyc;
      hold(1'b0, 4);
      hold(1'b1, 40);
      chk("fs_busy_before", 32'(hist_busy[e + 2]), 32'h0);
      chk("fs_busy_t0", 32'(hist_busy[e + 3]), 32'h1);
      chk("fs_busy_late", 32'(hist_busy[e + 10]), 32'h1);
      chk("fs_busy_fall", 32'(hist_busy[e + 11]), 32'h0);
      check_window("false_start", win, cyc - 1);

      // Bad stop bit followed by a 50-cycle break, then a good frame.
      win = cyc;
      e = cyc;
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 8'h00);
      hold(1'b0, 50);
      hold(1'b1, 20);
      send_frame(8'h41, 1'b1, 1'b1, 1'b1, 8'h41);
      hold(1'b1, 200);
      chk("brk_busy_wait", 32'(hist_busy[e + 180]), 32'h1);
      chk("brk_busy_last", 32'(hist_busy[e + 212]), 32'h1);
      chk("brk_busy_exit", 32'(hist_busy[e + 213]), 32'h0);
      check_window("break", win, cyc - 1);

      // Reset during data bit 3 of 0x44; the transmitter abandons the frame as well.
      win = cyc;
      hold(1'b0, CPB);
      hold(1'b0, CPB);
      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b0, 5);
      chk("rst_busy_before", 32'(busy_o), 32'h1);
      rst = 1'b1;
      rxd = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_ferr", 32'(frame_err_o), 32'h0);
      chk("rst_data", 32'(data_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      hold(1'b1, 40);
      send_frame(8'h43, 1'b1, 1'b1, 1'b1, 8'h43);
      hold(1'b1, 200);
      check_window("reset_mid", win, cyc - 1);

`ifdef UART_PARITY_EN
      win = cyc;
      send_frame(8'h43, 1'b1, 1'b0, 1'b0, 8'h00);
      hold(1'b1, 5);
      send_frame(8'h43, 1'b1, 1'b1, 1'b1, 8'h43);
      hold(1'b1, 200);
      check_window("parity", win, cyc - 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial byte receiver for the front end of the byte-pattern detection path. It recovers 8N1 (optionally 8E1) UART frames from an asynchronous line `rxd` and presents each received byte on `data_o` for exactly one clock cycle. Outside that cycle `data_o` is 0x00, so a per-clock byte consumer downstream sees every character exactly once.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are integers ≥ 4. Counter width is $clog2(CLKS_PER_BIT).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial line. Idle high, LSB first.
- `data_o`  out  8  received byte during the `valid_o` cycle; 0x00 at all other times.
- `valid_o`  out  1  one-cycle pulse when a good frame completes.
- `frame_err_o`  out  1  one-cycle pulse when a bad stop bit (or bad parity, see Configuration) is detected.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the second stage `rxd_s`.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HIGH.
- **IDLE:** if `rxd_s`=0, go to START and clear the bit-timer.
- **START:** at timer = CLKS_PER_BIT/2−1 (integer division), sample `rxd_s`.
  - If it is 1, this is a false start: return to IDLE with no output.
  - Otherwise go to DATA with bit index 0 and the timer cleared.
- **DATA:** at each timer = CLKS_PER_BIT−1, shift `rxd_s` into bit[index] (LSB first) and clear the timer. After index 7, go to PARITY (if enabled) or STOP.
- **STOP:** at timer = CLKS_PER_BIT−1, sample `rxd_s`.
  - If 1: load `data_o` with the byte, pulse `valid_o`, go to IDLE.
  - If 0: pulse `frame_err_o`, keep `data_o` at 0x00, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxd_s`=1, then go to IDLE. This absorbs break conditions without generating spurious frames.
- `data_o` is registered. It is cleared to 0x00 on every cycle in which `valid_o` is not being asserted.
- Reset values: `data_o`=0x00, `valid_o`=0, `frame_err_o`=0, `busy_o`=0, state IDLE, timer 0, shift register 0x00.
- Reset mid-frame aborts the frame with no output. The first frame whose start bit falls after reset deassertion is received normally.
- `valid_o` and `frame_err_o` are never high in the same cycle.

## Timing
- T0 is the clock edge at which the FSM enters START. The line falling edge reaches `rxd_s` 2 cycles after it meets the first flop's setup time.
- Start mid-sample: edge T0 + CLKS_PER_BIT/2.
- Data bit i sample (i = 0..7): edge T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: edge T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT without parity, or +10·CLKS_PER_BIT with parity.
- `valid_o`/`frame_err_o` and `data_o` are set at the stop-sample edge and held for exactly 1 cycle.
- The FSM is back in IDLE at the stop-sample edge. The next start bit is detected with no dead time, so back-to-back frames with a single stop bit are supported.
- `busy_o` rises at T0 and falls at the stop-sample edge, or at the exit from WAIT_HIGH.

## Configuration
- `UART_PARITY_EN` defined:
  - The PARITY state is compiled in. It samples one extra bit at timer = CLKS_PER_BIT−1 after bit 7.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - On mismatch, the frame still proceeds to STOP. At the stop-sample edge, `frame_err_o` pulses, `valid_o` stays 0, and the next state is IDLE if the stop bit is 1, or WAIT_HIGH if it is 0.
- `UART_PARITY_EN` undefined: the PARITY state and checker are absent, and the frame is 10 bits.

## Test plan
- CLKS_PER_BIT=16, send 0x43 → `valid_o`=1 and `data_o`=0x43 for one cycle at edge T0+8+144. `data_o`=0x00 before and after.
- Back-to-back frames 0x43, 0x44, 0x41, 0x43 with one stop bit each → exactly four `valid_o` pulses in order, 160 cycles apart. `data_o`=0x00 between pulses.
- `rxd` low for 4 cycles, then high → no `valid_o`, no `frame_err_o`. `busy_o` returns to 0 at edge T0+8.
- Frame 0x55 with stop bit 0, line held low 50 cycles, then high, then frame 0x41 → one `frame_err_o` pulse, no `valid_o` for 0x55, then 0x41 delivered correctly.
- `rst` asserted for 1 cycle during data bit 3 of frame 0x44 → all outputs 0 from the next cycle, no pulse for the aborted frame. The next frame, 0x43, is received correctly.
- With `UART_PARITY_EN`, send 0x43 with parity bit 0 (correct bit is 1) → `frame_err_o` pulse at the stop-sample edge, no `valid_o`. The same byte with parity 1 → `valid_o` with 0x43.
